uart_tx_periph: RTL
===================

# uart_tx_periph

Memory-mapped UART transmitter peripheral and data-bus responder for the unicycle RISC-V core. It decodes load/store accesses from the core's data port and buffers written bytes in a 4-entry FIFO. It serialises those bytes as 8N1 frames on `tx` at a programmable baud divisor. Reads are combinational so the single-cycle core can complete a load in the same cycle.

## Interface
- `W`, default 32: data bus width.
- `DIV_RST`, default 434: reset value of the baud divisor, in clock cycles per bit.
- `DEPTH`, default 4: TX FIFO depth. Must be a power of two.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `sel`, input, 1: peripheral select from the core's address decode.
- `we`, input, 1: store when high, load when low. Only meaningful with `sel`.
- `addr`, input, 4: byte offset; bits [3:2] select the register, bits [1:0] are ignored.
- `wdata`, input, W: store data.
- `rdata`, output, W: load data, combinational from `addr`. Reads 0 when `sel`=0.
- `tx`, output, 1: serial output, idle high, registered.
- `irq`, output, 1: level interrupt, registered.

## Operation
- Register map:
  - 0x0 DATA. A write pushes `wdata[7:0]` into the FIFO. A read returns 0.
  - 0x4 STATUS, read-only except bit3:
    - bit0 full, bit1 empty, bit2 busy (shifter not IDLE), bit3 overflow (sticky).
    - bits[6:4] FIFO count (0..DEPTH); other bits 0.
    - Writing 1 to bit3 clears overflow.
  - 0x8 CTRL, read/write: bit0 enable, bit1 irq_en; other bits read 0.
  - 0xC DIV, read/write: bits[15:0] divisor. A written value of 0 is stored as 1.
- A push to a full FIFO is dropped and sets overflow. A push and a pop in the same cycle on a full FIFO is accepted; count is unchanged.
- Shifter FSM: IDLE -> START -> DATA -> STOP -> IDLE or START.
  - IDLE: if enable=1 and the FIFO is non-empty, pop the head byte, latch DIV into the bit-period register, and go to START.
  - START: `tx`=0 for one bit period.
  - DATA: 8 bits, LSB first, one bit period each, with a 3-bit bit index.
  - STOP: `tx`=1 for one bit period. In its final cycle, if enable=1 and the FIFO is non-empty, pop, relatch DIV and go to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- Bit period = latched DIV cycles. A DIV write mid-frame affects only the next frame.
- Clearing enable mid-frame: the current frame completes; no further pops.
- `irq` = irq_en & empty & !busy, registered (one-cycle delay from the condition).
- Reset:
  - `tx`=1, `irq`=0, FSM IDLE, FIFO empty, overflow=0, CTRL=0, DIV=DIV_RST.
  - Reads immediately after reset: STATUS=0x02, CTRL=0, DIV=DIV_RST.

## Timing
- Store accepted at the edge where `sel`&`we`=1. The FIFO reflects the push from the next cycle.
- First frame: with enable already 1, a DATA write at edge N pops at edge N+1. `tx` falls at edge N+1. The start bit occupies edges N+1..N+1+DIV.
- Frame length is exactly 10×DIV cycles. Back-to-back frames have a start-bit edge exactly 10×DIV after the previous one.
- `rdata` is valid in the same cycle as `addr`/`sel`. STATUS reflects the registered state, not the write occurring that cycle.
- Asserting `rst` low mid-frame forces `tx` high asynchronously and discards the FIFO contents.
- Simultaneous DATA write and pop on an empty FIFO is impossible: a pop requires non-empty at the edge, so the byte goes out one cycle later.

## Test plan
- Reset → STATUS=0x02, CTRL=0, DIV=434, `tx`=1, `irq`=0. Hold `rst` low mid-frame → `tx`=1 immediately.
- DIV=4, CTRL=1, DATA=0x55 → `tx` sequence 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop). Each bit lasts 4 cycles; 40 cycles total; busy then clears.
- CTRL=0, write 5 bytes → count=4, full=1, overflow=1. Write STATUS=0x8 → overflow=0.
- DIV=2, CTRL=1, write 0xA5 and 0x3C → two frames with no idle gap; second start bit exactly 20 cycles after the first.
- DIV=8, start 0xFF, write DIV=2 mid-frame → first frame keeps 8-cycle bits, second uses 2-cycle bits. Write DIV=0 → reads 1.
- CTRL=0x3, send one byte → `irq` rises one cycle after busy and empty are both true. CTRL=0x1 → `irq`=0.

Source files
------------

// File: rtl/uart_tx_periph.sv
// uart_tx_periph
// Memory-mapped 8N1 UART transmitter for the unicycle RISC-V core data port.
// Stores to DATA fill a small TX FIFO; a shifter FSM drains it onto tx at a
// programmable bit period. Loads are combinational so a single-cycle core
// can complete them in the same cycle.
//
// Ports:
//   clk    - single clock, rising edge
//   rst    - asynchronous reset, active low
//   sel    - peripheral select from core address decode
//   we     - 1 = store, 0 = load (qualified by sel)
//   addr   - byte offset; [3:2] picks DATA/STATUS/CTRL/DIV, [1:0] ignored
//   wdata  - store data
//   rdata  - load data, combinational, 0 when sel=0
//   tx     - serial output, idle high, registered
//   irq    - level interrupt (irq_en & empty & !busy), registered
module uart_tx_periph #(
  parameter int W       = 32,
  parameter int DIV_RST = 434,
  parameter int DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sel,
  input  logic         we,
  input  logic [3:0]   addr,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         tx,
  output logic         irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Control/status registers
  logic          r_en;
  logic          r_irq_en;
  logic [15:0]   r_div;
  logic          r_ovf;
  logic          r_irq;

  // FIFO
  logic [7:0]    r_fifo [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  // Shifter
  state_t        r_state;
  logic [15:0]   r_cnt;
  logic [15:0]   r_bitper;
  logic [2:0]    r_bitidx;
  logic [7:0]    r_shift;
  logic          r_tx;

  // Next-state values from the shifter FSM
  state_t        w_state_nxt;
  logic [15:0]   w_cnt_nxt;
  logic [15:0]   w_bitper_nxt;
  logic [2:0]    w_bitidx_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_tx_nxt;
  logic          w_pop;

  logic          w_full;
  logic          w_empty;
  logic          w_busy;
  logic          w_wr;
  logic          w_wr_data;
  logic          w_push_ok;
  logic          w_bit_end;
  logic          w_can_pop;
  logic [15:0]   w_div_wr;
  logic [7:0]    w_head;
  logic          w_unused_ok;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_busy    = (r_state != S_IDLE);
  assign w_wr      = sel & we;
  assign w_wr_data = w_wr & (addr[3:2] == 2'd0);
  // A full FIFO still accepts a push when the shifter pops in the same cycle.
  assign w_push_ok = w_wr_data & (~w_full | w_pop);
  assign w_bit_end = (r_cnt == (r_bitper - 16'd1));
  assign w_can_pop = r_en & ~w_empty;
  assign w_div_wr  = (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
  assign w_head    = r_fifo[r_rptr];
  assign w_unused_ok = &{1'b0, addr[1:0], wdata[W-1:16]};

  assign tx  = r_tx;
  assign irq = r_irq;

  // Register reads: STATUS shows registered state only
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr[3:2])
        2'd1: begin
          rdata[0]   = w_full;
          rdata[1]   = w_empty;
          rdata[2]   = w_busy;
          rdata[3]   = r_ovf;
          rdata[6:4] = 3'(r_count);
        end
        2'd2:    rdata[1:0]  = {r_irq_en, r_en};
        2'd3:    rdata[15:0] = r_div;
        default: rdata = '0;
      endcase
    end
  end

  // Register file and FIFO bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_div    <= 16'(DIV_RST);
      r_ovf    <= 1'b0;
      r_irq    <= 1'b0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr && addr[3:2] == 2'd2) begin
        r_en     <= wdata[0];
        r_irq_en <= wdata[1];
      end
      if (w_wr && addr[3:2] == 2'd3) r_div <= w_div_wr;

      if (w_wr_data && !w_push_ok)                   r_ovf <= 1'b1;
      else if (w_wr && addr[3:2] == 2'd1 && wdata[3]) r_ovf <= 1'b0;

      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      r_irq <= r_irq_en & w_empty & ~w_busy;
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by r_count
  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wptr] <= wdata[7:0];
  end

  // Shifter state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bitper <= 16'd1;
      r_bitidx <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bitper <= w_bitper_nxt;
      r_bitidx <= w_bitidx_nxt;
      r_shift  <= w_shift_nxt;
      r_tx     <= w_tx_nxt;
    end
  end

  // Shifter next-state: tx is registered, so each transition sets the level
  // for the bit that starts at that edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + 16'd1;
    w_bitper_nxt = r_bitper;
    w_bitidx_nxt = r_bitidx;
    w_shift_nxt  = r_shift;
    w_tx_nxt     = r_tx;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_tx_nxt  = 1'b1;
        if (w_can_pop) begin
          w_pop        = 1'b1;
          w_shift_nxt  = w_head;
          w_bitper_nxt = r_div;
          w_tx_nxt     = 1'b0;
          w_state_nxt  = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_cnt_nxt    = '0;
          w_bitidx_nxt = '0;
          w_tx_nxt     = r_shift[0];
          w_state_nxt  = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_bitidx == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
          end else begin
            w_bitidx_nxt = r_bitidx + 3'd1;
            w_shift_nxt  = {1'b0, r_shift[7:1]};
            w_tx_nxt     = r_shift[1];
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          // Chain straight into the next start bit to avoid an idle gap
          if (w_can_pop) begin
            w_pop        = 1'b1;
            w_shift_nxt  = w_head;
            w_bitper_nxt = r_div;
            w_tx_nxt     = 1'b0;
            w_state_nxt  = S_START;
          end else begin
            w_state_nxt  = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
